// File: rtl/icache_fetch_port.sv
// icache_fetch_port: direct-mapped, one-word-per-line instruction cache sitting
// between the instruction fetcher and the byte-wide shared memory port.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   rdy_in              global ready; low freezes every register
//   _clear              branch flush; aborts the current fetch, array untouched
//   _need_inst, _pc_in  fetch request (held until served) and its address
//   _inst_ready_out     one-cycle pulse marking _inst_out valid
//   _inst_out           fetched instruction, little-endian assembled
//   _mem_req, _mem_a    memory port request and byte address
//   _mem_grant          arbiter grant; the address on _mem_a issues this cycle
//   _mem_din            byte returned the cycle after a granted address
module icache_fetch_port #(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _need_inst,
    input  logic [31:0] _pc_in,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_out,
    output logic        _mem_req,
    input  logic        _mem_grant,
    output logic [31:0] _mem_a,
    input  logic [7:0]  _mem_din
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state;

    // Cache array: valid bits are resettable, tag/data storage is not.
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [31:0]       data [LINES];

    logic [29:0]       base_word;   // word address of the line being refilled
    logic [2:0]        addr_cnt;    // addresses issued so far (0..4)
    logic [1:0]        byte_cnt;    // bytes captured so far
    logic              inflight;    // a byte is due on _mem_din this cycle
    logic [23:0]       asm_buf;     // lanes 0..2; lane 3 comes straight off _mem_din

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  issue;
    logic [31:0]           fill_word;

    // Low PC bits are ignored; latency is fixed at one cycle.
    logic unused_cfg;
    assign unused_cfg = ^{_pc_in[1:0], 1'(MEM_LATENCY != 1)};

    assign req_idx   = _pc_in[INDEX_BITS+1:2];
    assign req_tag   = _pc_in[31:INDEX_BITS+2];
    assign fill_idx  = base_word[INDEX_BITS-1:0];
    assign fill_tag  = base_word[29:INDEX_BITS];
    assign hit       = valid[req_idx] && (tags[req_idx] == req_tag);
    assign issue     = (addr_cnt < 3'd4) && _mem_grant;
    assign fill_word = {_mem_din, asm_buf};

    // Control FSM, refill datapath and cache array update.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            valid           <= '0;
            base_word       <= '0;
            addr_cnt        <= '0;
            byte_cnt        <= '0;
            inflight        <= 1'b0;
            asm_buf         <= '0;
            _inst_ready_out <= 1'b0;
            _inst_out       <= '0;
            _mem_req        <= 1'b0;
            _mem_a          <= '0;
        end else if (rdy_in) begin
            _inst_ready_out <= 1'b0;
            if (_clear) begin
                // Abort: drop partial line and ignore the byte still in flight.
                state    <= IDLE;
                addr_cnt <= '0;
                byte_cnt <= '0;
                inflight <= 1'b0;
                _mem_req <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // A pulse this cycle means the held request was just served.
                        if (_need_inst && !_inst_ready_out) begin
                            base_word <= _pc_in[31:2];
                            if (hit) begin
                                _inst_out       <= data[req_idx];
                                _inst_ready_out <= 1'b1;
                            end else begin
                                state    <= REFILL;
                                addr_cnt <= '0;
                                byte_cnt <= '0;
                                inflight <= 1'b0;
                                _mem_req <= 1'b1;
                                _mem_a   <= {_pc_in[31:2], 2'b00};
                            end
                        end
                    end
                    REFILL: begin
                        inflight <= issue;
                        if (issue) begin
                            addr_cnt <= addr_cnt + 3'd1;
                            _mem_a   <= {base_word, 2'b00} + 32'(addr_cnt) + 32'd1;
                            _mem_req <= (addr_cnt != 3'd3);
                        end
                        if (inflight) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            case (byte_cnt)
                                2'd0: asm_buf[7:0]   <= _mem_din;
                                2'd1: asm_buf[15:8]  <= _mem_din;
                                2'd2: asm_buf[23:16] <= _mem_din;
                                default: begin
                                    // Last byte: install the line and answer the fetcher.
                                    valid[fill_idx] <= 1'b1;
                                    tags[fill_idx]  <= fill_tag;
                                    data[fill_idx]  <= fill_word;
                                    _inst_out       <= fill_word;
                                    _inst_ready_out <= 1'b1;
                                    state           <= IDLE;
                                    addr_cnt        <= '0;
                                    byte_cnt        <= '0;
                                    inflight        <= 1'b0;
                                    _mem_req        <= 1'b0;
                                end
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
